// File: rtl/mv_frame_serializer.sv
// mv_frame_serializer
// Captures A/B/C byte triplets into a small FIFO. Each triplet is then sent
// on an 8-bit valid/ready stream as one frame: header, A, B, C.
// sat_count is a saturating count of accepted triplets whose lane A is 8'hFF.
// Optional build macro MV_FRAME_CHK_EN: appends a checksum byte
// (A ^ B ^ C ^ HDR_BYTE) to each frame. out_last then marks the checksum byte.
module mv_frame_serializer #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5,
  parameter int          SAT_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  input  logic [7:0]               in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [SAT_CNT_W-1:0]     sat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, BA, BB, BC, CHK} state_t;

`ifdef MV_FRAME_CHK_EN
  localparam bit     CHK_EN  = 1'b1;
  localparam state_t LAST_ST = CHK;
`else
  localparam bit     CHK_EN  = 1'b0;
  localparam state_t LAST_ST = BC;
`endif

  logic [23:0]          mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          level_reg;
  logic [23:0]          frame_reg;
  logic [SAT_CNT_W-1:0] sat_reg;
  state_t               state_reg;
  logic                 out_valid_reg;
  logic [7:0]           out_data_reg;
  logic                 out_last_reg;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [7:0] chk_byte;

  assign full  = (level_reg == FULL_LEVEL);
  assign empty = (level_reg == '0);
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign push  = in_valid && !full;
  // Pops happen when IDLE sees data, or when the final byte of a frame is
  // accepted and another triplet is waiting (no gap between frames).
  assign pop   = !empty && ((state_reg == IDLE) ||
                            (state_reg == LAST_ST && out_ready));
  assign chk_byte = frame_reg[23:16] ^ frame_reg[15:8] ^ frame_reg[7:0] ^ HDR_BYTE;

  assign in_ready   = !full;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_last   = out_last_reg;
  assign fifo_level = level_reg;
  assign sat_count  = sat_reg;

  // Storage array write port. It has no reset because its contents are
  // meaningless while the level is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {in_a, in_b, in_c};
  end

  // Registered read into the frame register. A word pushed this cycle is
  // therefore visible no sooner than the next cycle.
  always_ff @(posedge clk) begin
    if (pop) frame_reg <= mem[rd_ptr_reg];
  end

  // Pointers and occupancy. A push and a pop in the same cycle leave the level unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Saturated-lane-A counter. It sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_reg <= '0;
    end else if (push && in_a == 8'hFF && sat_reg != '1) begin
      sat_reg <= sat_reg + 1'b1;
    end
  end

  // Frame sequencer with registered outputs. These outputs only change when
  // a byte is accepted, so they stay stable while the stream is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!empty) begin
            state_reg     <= HDR;
            out_valid_reg <= 1'b1;
            out_data_reg  <= HDR_BYTE;
            out_last_reg  <= 1'b0;
          end
        end
        HDR: begin
          if (out_ready) begin
            state_reg    <= BA;
            out_data_reg <= frame_reg[23:16];
          end
        end
        BA: begin
          if (out_ready) begin
            state_reg    <= BB;
            out_data_reg <= frame_reg[15:8];
          end
        end
        BB: begin
          if (out_ready) begin
            state_reg    <= BC;
            out_data_reg <= frame_reg[7:0];
            out_last_reg <= !CHK_EN;
          end
        end
        BC, CHK: begin
          if (out_ready) begin
            if (CHK_EN && state_reg == BC) begin
              state_reg    <= CHK;
              out_data_reg <= chk_byte;
              out_last_reg <= 1'b1;
            end else if (!empty) begin
              state_reg    <= HDR;
              out_data_reg <= HDR_BYTE;
              out_last_reg <= 1'b0;
            end else begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              out_data_reg  <= 8'h00;
              out_last_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          out_data_reg  <= 8'h00;
          out_last_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mv_frame_serializer.sv
// Testbench for mv_frame_serializer: randomized and directed stimulus.
// A recorder turns each accepted triplet into its expected frame bytes.
// A monitor compares every accepted output byte against that queue.
module tb_mv_frame_serializer;

  localparam int         DEPTH = 4;
  localparam int         SAT_W = 4;
  localparam logic [7:0] HDR   = 8'hA5;
`ifdef MV_FRAME_CHK_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [7:0]             in_a = 8'h00;
  logic [7:0]             in_b = 8'h00;
  logic [7:0]             in_c = 8'h00;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [7:0]             out_data;
  logic                   out_last;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [SAT_W-1:0]       sat_count;

  always #5 clk = ~clk;

  mv_frame_serializer #(
    .DEPTH(DEPTH), .HDR_BYTE(HDR), .SAT_CNT_W(SAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .fifo_level(fifo_level), .sat_count(sat_count)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {last, data}
  int sat_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Recorder: builds the expected frame for each accepted triplet and tracks sat_count.
  logic [7:0] rec_ck;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      sat_model = 0;
    end else begin
      check("sat_count", 32'(sat_count), 32'(sat_model));
      if (in_valid && in_ready) begin
        rec_ck = in_a ^ in_b ^ in_c ^ HDR;
        exp_q.push_back({1'b0, HDR});
        exp_q.push_back({1'b0, in_a});
        exp_q.push_back({1'b0, in_b});
        if (FLEN == 5) begin
          exp_q.push_back({1'b0, in_c});
          exp_q.push_back({1'b1, rec_ck});
        end else begin
          exp_q.push_back({1'b1, in_c});
        end
        if (in_a == 8'hFF && sat_model < SAT_MAX) sat_model++;
        $display("push a=%h b=%h c=%h t=%0t", in_a, in_b, in_c, $time);
      end
    end
  end

  // Monitor: checks stall stability and compares each accepted byte.
  logic       stall_prev = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  logic [8:0] mon_e;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", {23'd0, out_last, out_data}, {23'd0, held_last, held_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%h required=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("byte", {23'd0, out_last, out_data}, {23'd0, mon_e});
          $display("byte data=%h last=%b t=%0t", out_data, out_last, $time);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int n = 0;
    in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("push_timeout", 32'(n), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sat", 32'(sat_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single frame and its latency
    out_ready = 1'b1;
    in_a = 8'h10; in_b = 8'h11; in_c = 8'h12; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("lat_t2_data", 32'(out_data), 32'hA5);
    check("lat_t2_last", 32'(out_last), 32'd0);
    drain();
    check("sat_after_1", 32'(sat_count), 32'd0);

    // Saturated lane A
    push_one(8'hFF, 8'h7A, 8'h7B);
    drain();
    check("sat_after_2", 32'(sat_count), 32'd1);

    // Backpressure: five back-to-back pushes into a stalled stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("bp_level", 32'(fifo_level), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'hA5);
    in_a = 8'hEE; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_refused_level", 32'(fifo_level), 32'd4);
    check("bp_hold_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    for (int i = 0; i < 5 * FLEN; i++) begin
      check("contig_valid", 32'(out_valid), 32'd1);
      tick();
    end
    check("contig_end_valid", 32'(out_valid), 32'd0);
    check("contig_queue", 32'(exp_q.size()), 32'd0);

    // Toggling out_ready during frames
    out_ready = 1'b0;
    push_one(8'($urandom), 8'($urandom), 8'($urandom));
    push_one(8'hFF, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      out_ready = i[0];
      tick();
    end
    drain();

    // Reset while in BB with two FIFO entries
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(8'h20 + i); in_b = 8'(8'h40 + i); in_c = 8'(8'h60 + i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("mid_pre_level", 32'(fifo_level), 32'd2);
    check("mid_pre_data", 32'(out_data), 32'h40);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sat", 32'(sat_count), 32'd0);
    reset = 1'b0;
    tick();
    push_one(8'h01, 8'h02, 8'h03);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 2) == 0;
      in_a      = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
      in_b      = 8'($urandom);
      in_c      = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Saturation of sat_count
    do_reset();
    check("satrun_start", 32'(sat_count), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < (1 << SAT_W) + 3; k++) begin
      push_one(8'hFF, 8'($urandom), 8'($urandom));
    end
    drain();
    check("satrun_hold", 32'(sat_count), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mv_frame_serializer.md
Name: mv_frame_serializer

Overview:
- Downstream consumer of the registered three-lane byte stage (lanes A/B/C, lane A saturating to 8'hFF on large inputs).
- Captures each valid A/B/C triplet into a small FIFO.
- Serializes each triplet onto an 8-bit valid/ready stream as a framed packet: header, A, B, C.
- Counts frames whose lane A arrived saturated.

Parameters:
DEPTH, 4, FIFO entries of 24 bits; power of two, >= 2
HDR_BYTE, 8'hA5, header byte emitted at the start of every frame
SAT_CNT_W, 16, width of the saturated-frame counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  triplet on in_a/in_b/in_c is valid
in_ready  output  1  FIFO can accept a triplet (= !full)
in_a  input  8  lane A byte (8'hFF = saturated)
in_b  input  8  lane B byte
in_c  input  8  lane C byte
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  8  serialized frame byte
out_last  output  1  marks final byte of a frame
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
sat_count  output  SAT_CNT_W  saturating count of accepted triplets with in_a == 8'hFF

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous and active-high.
  - Reset values: FIFO empty, fifo_level 0, in_ready 1, out_valid 0, out_data 8'h00, out_last 0, sat_count 0, FSM in IDLE.
  - Reset mid-frame discards the frame and all FIFO contents; there is no partial-frame completion.
- Push:
  - Occurs when in_valid && in_ready; stores {in_a,in_b,in_c}.
  - in_ready is combinational !full.
  - When full, push is refused even if a pop occurs in the same cycle.
- sat_count:
  - Increments on each push with in_a == 8'hFF.
  - Holds at all-ones and does not wrap.
- Pop:
  - Performed only by the FSM, into an internal frame register.
  - No bypass: a word pushed into an empty FIFO is poppable the next cycle.
  - fifo_level reflects push and pop in the same cycle (net 0).
- FSM states: IDLE, HDR, BA, BB, BC. Transitions:
  - IDLE: if FIFO non-empty, pop and go to HDR.
  - HDR: out_data = HDR_BYTE; on out_ready go to BA.
  - BA: out_data = A; on out_ready go to BB.
  - BB: out_data = B; on out_ready go to BC.
  - BC: out_data = C with out_last = 1. On out_ready:
    - if FIFO non-empty, pop and go to HDR (no bubble between frames);
    - else go to IDLE.
- Output handshake:
  - out_valid = 1 in every state except IDLE.
  - out_data, out_last and out_valid are registered.
  - While out_valid && !out_ready, they stay stable.
  - A byte advances only on out_valid && out_ready.
- Latency: push at cycle T into an empty FIFO with FSM in IDLE → pop at T+1 → header valid at T+2. Minimum frame occupancy is 4 cycles.
- Throughput: one byte per cycle with out_ready held high. Sustained input rate is one triplet per 4 cycles; faster input fills the FIFO and deasserts in_ready.
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from the extra-bit occupancy.

Optional Feature:
MV_FRAME_CHK_EN
- Defined:
  - Adds state CHK after BC. CHK emits the checksum A ^ B ^ C ^ HDR_BYTE.
  - out_last moves from BC to CHK.
  - Frame length is 5 bytes.
  - The back-to-back and IDLE decision moves from BC to CHK.
- Undefined: 4-byte frames exactly as described above.

Test Plan:
- Reset, then single push a=8'h10, b=8'h11, c=8'h12, out_ready=1 → bytes A5,10,11,12 on cycles T+2..T+5; out_last only on 12; sat_count 0.
- Push a=8'hFF, b=8'h7A, c=8'h7B → frame A5,FF,7A,7B; sat_count 1. With MV_FRAME_CHK_EN, 5th byte = FF^7A^7B^A5 = 8'h5B with out_last.
- out_ready=0, push 5 triplets back-to-back with DEPTH=4:
  - the first triplet is popped on the next cycle, so the FIFO absorbs 4 more (5 accepted in total);
  - fifo_level reaches 4 with in_ready=0 while the header is stalled;
  - out_data stays A5 throughout;
  - release out_ready → 5 frames, contiguous, no idle cycle between frames.
- Toggle out_ready every cycle during a frame → each byte held stable until accepted; byte order and out_last unchanged.
- Assert reset while in state BB with 2 FIFO entries → next cycle out_valid=0, fifo_level=0, in_ready=1, sat_count=0; next push produces a clean frame.
- Push 2^SAT_CNT_W+3 saturated triplets (SAT_CNT_W overridden to 4) → sat_count holds at 4'hF.
